fetch_sequencer: RTL and testbench

- Controller that drives PROGRAM_MEMORY's fetch-control inputs: pc_mux_sel, jump_loc, stall and stall_pm.
- Arbitrates between reset boot, taken branches/jumps, load-use hazards, data-memory wait and halt requests.
- Generates pipeline flush strobes.
- Sits between the execute/hazard logic and the instruction-fetch stage.

---
 rtl/fetch_sequencer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Drives the fetch-control inputs of the program memory: PC mux select,
// redirect address and the two stall signals. It arbitrates between the boot
// sequence, taken branches, load-use hazards, data-memory wait and halt
// requests. It also produces the IF/ID and ID/EX flush strobes.
//
// All outputs are registered (Moore). The output values are decoded from the
// next state and loaded on the same edge as the state register, so a sampled
// input shows its effect on the very next edge.
//
// Optional build macro: STALL_PERF_CNT_EN
//   When defined, stall_cycles counts the cycles with stall=1 and saturates
//   at 16'hFFFF.
//   When undefined, stall_cycles is tied to zero.
//
// Ports:
//   clk              system clock, rising edge
//   reset            asynchronous active-low reset
//   branch_req       taken branch, held high until branch_ack
//   branch_target    redirect target, stable while branch_req is high
//   load_use_hazard  one-cycle hazard flag from decode
//   dm_busy          data memory not ready
//   halt_req         level halt request
//   resume           pulse that leaves HALT
//   pc_mux_sel       1 = load jump_loc into the PC, 0 = PC+1
//   jump_loc         redirect address (changes only in BOOT / REDIRECT)
//   stall            freeze the PC
//   stall_pm         freeze the program-memory output register
//   flush_if_id      squash the IF/ID register
//   flush_id_ex      squash the ID/EX register (insert a bubble)
//   branch_ack       one-cycle pulse when the redirect is issued
//   stall_timeout    sticky flag, set when MEM_WAIT lasts STALL_MAX cycles
//   state_out        current state, for debug
//   stall_cycles     stall performance counter (optional)
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC    = 16'h0000,
    parameter int                FLUSH_CYCLES = 2,
    parameter int                STALL_MAX    = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              branch_req,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              load_use_hazard,
    input  logic              dm_busy,
    input  logic              halt_req,
    input  logic              resume,
    output logic              pc_mux_sel,
    output logic [ADDR_W-1:0] jump_loc,
    output logic              stall,
    output logic              stall_pm,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              branch_ack,
    output logic              stall_timeout,
    output logic [2:0]        state_out,
    output logic [15:0]       stall_cycles
);

    typedef enum logic [2:0] {
        S_BOOT     = 3'd0,
        S_RUN      = 3'd1,
        S_HAZARD   = 3'd2,
        S_MEM_WAIT = 3'd3,
        S_REDIRECT = 3'd4,
        S_FLUSH    = 3'd5,
        S_HALT     = 3'd6
    } state_t;

    // Number of FLUSH cycles that follow REDIRECT.
    localparam logic [2:0] FLUSH_INIT  = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] STALL_MAX_C = 8'(STALL_MAX);

    state_t              state_reg, state_next;
    logic                boot_done_reg, boot_done_next;
    logic [2:0]          flush_cnt_reg, flush_cnt_next;
    logic [7:0]          wait_cnt_reg, wait_cnt_next;

    logic                pc_mux_sel_reg, pc_mux_sel_next;
    logic [ADDR_W-1:0]   jump_loc_reg, jump_loc_next;
    logic                stall_reg, stall_next;
    logic                stall_pm_reg, stall_pm_next;
    logic                flush_if_id_reg, flush_if_id_next;
    logic                flush_id_ex_reg, flush_id_ex_next;
    logic                branch_ack_reg, branch_ack_next;
    logic                stall_timeout_reg, stall_timeout_next;

    // -----------------------------------------------------------------------
    // State register, with the output registers and the internal counters
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg         <= S_BOOT;
            boot_done_reg     <= 1'b0;
            flush_cnt_reg     <= '0;
            wait_cnt_reg      <= '0;
            pc_mux_sel_reg    <= 1'b1;
            jump_loc_reg      <= RESET_VEC;
            stall_reg         <= 1'b0;
            stall_pm_reg      <= 1'b1;
            flush_if_id_reg   <= 1'b0;
            flush_id_ex_reg   <= 1'b0;
            branch_ack_reg    <= 1'b0;
            stall_timeout_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            boot_done_reg     <= boot_done_next;
            flush_cnt_reg     <= flush_cnt_next;
            wait_cnt_reg      <= wait_cnt_next;
            pc_mux_sel_reg    <= pc_mux_sel_next;
            jump_loc_reg      <= jump_loc_next;
            stall_reg         <= stall_next;
            stall_pm_reg      <= stall_pm_next;
            flush_if_id_reg   <= flush_if_id_next;
            flush_id_ex_reg   <= flush_id_ex_next;
            branch_ack_reg    <= branch_ack_next;
            stall_timeout_reg <= stall_timeout_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        boot_done_next = boot_done_reg;
        flush_cnt_next = flush_cnt_reg;
        wait_cnt_next  = wait_cnt_reg;

        case (state_reg)
            // BOOT spends one edge presenting RESET_VEC with the program
            // memory unfrozen, then moves to RUN on the following edge.
            S_BOOT: begin
                if (!boot_done_reg) begin
                    boot_done_next = 1'b1;
                end else begin
                    state_next = S_RUN;
                end
            end
            // Priority: halt > branch > memory wait > load-use hazard.
            S_RUN: begin
                if (halt_req) begin
                    state_next = S_HALT;
                end else if (branch_req) begin
                    state_next     = S_REDIRECT;
                    flush_cnt_next = FLUSH_INIT;
                end else if (dm_busy) begin
                    state_next    = S_MEM_WAIT;
                    wait_cnt_next = 8'd1;
                end else if (load_use_hazard) begin
                    state_next = S_HAZARD;
                end
            end
            S_HAZARD: begin
                state_next = S_RUN;
            end
            // Nothing but dm_busy is looked at here. A branch that arrives
            // meanwhile stays pending and is taken once the FSM is in RUN.
            S_MEM_WAIT: begin
                if (dm_busy) begin
                    if (wait_cnt_reg != 8'hFF) begin
                        wait_cnt_next = wait_cnt_reg + 8'd1;
                    end
                end else begin
                    state_next = S_RUN;
                end
            end
            // flush_cnt_reg holds the number of FLUSH cycles still to come.
            // No requests are sampled until the FSM is back in RUN.
            S_REDIRECT, S_FLUSH: begin
                if (flush_cnt_reg == 3'd0) begin
                    state_next = S_RUN;
                end else begin
                    state_next     = S_FLUSH;
                    flush_cnt_next = flush_cnt_reg - 3'd1;
                end
            end
            S_HALT: begin
                if (resume) begin
                    state_next = S_RUN;
                end
            end
            default: begin
                state_next = S_BOOT;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode, taken from the next state (these values get registered)
    // -----------------------------------------------------------------------
    always_comb begin
        pc_mux_sel_next    = 1'b0;
        jump_loc_next      = jump_loc_reg;
        stall_next         = 1'b0;
        stall_pm_next      = 1'b0;
        flush_if_id_next   = 1'b0;
        flush_id_ex_next   = 1'b0;
        branch_ack_next    = 1'b0;
        stall_timeout_next = stall_timeout_reg;

        case (state_next)
            S_BOOT: begin
                pc_mux_sel_next = 1'b1;
                jump_loc_next   = RESET_VEC;
            end
            S_HAZARD: begin
                stall_next       = 1'b1;
                stall_pm_next    = 1'b1;
                flush_id_ex_next = 1'b1;
            end
            S_MEM_WAIT: begin
                stall_next    = 1'b1;
                stall_pm_next = 1'b1;
                if (wait_cnt_next >= STALL_MAX_C) begin
                    stall_timeout_next = 1'b1;
                end
            end
            S_REDIRECT: begin
                pc_mux_sel_next  = 1'b1;
                jump_loc_next    = branch_target;
                flush_if_id_next = 1'b1;
                flush_id_ex_next = 1'b1;
                branch_ack_next  = 1'b1;
            end
            S_FLUSH: begin
                flush_if_id_next = 1'b1;
            end
            S_HALT: begin
                stall_next    = 1'b1;
                stall_pm_next = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign pc_mux_sel    = pc_mux_sel_reg;
    assign jump_loc      = jump_loc_reg;
    assign stall         = stall_reg;
    assign stall_pm      = stall_pm_reg;
    assign flush_if_id   = flush_if_id_reg;
    assign flush_id_ex   = flush_id_ex_reg;
    assign branch_ack    = branch_ack_reg;
    assign stall_timeout = stall_timeout_reg;
    assign state_out     = state_reg;

`ifdef STALL_PERF_CNT_EN
    // This counter is incremented from stall_next, so its value already
    // includes the stall cycle that is being presented.
    logic [15:0] stall_cycles_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_reg <= '0;
        end else if (stall_next && (stall_cycles_reg != 16'hFFFF)) begin
            stall_cycles_reg <= stall_cycles_reg + 16'd1;
        end
    end

    assign stall_cycles = stall_cycles_reg;
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed scoreboard bench for fetch_sequencer with the default parameters
// (FLUSH_CYCLES=2, STALL_MAX=15).
//
// The stimulus process drives the inputs. It then queues the output vector
// expected after the coming clock edge, tagged with that edge's cycle number.
// The monitor pops the queued entries and compares them on the falling edge.
// It also compares at once when the stimulus fires chk_ev, which is how the
// asynchronous reset is checked between clock edges.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    typedef struct packed {
        logic [2:0]  st;
        logic        pcm;
        logic [15:0] jl;
        logic        stl;
        logic        spm;
        logic        fif;
        logic        fid;
        logic        ack;
        logic        to;
        logic [15:0] sc;
    } out_t;

    localparam logic [2:0] BOOT = 3'd0, RUN = 3'd1, HAZ = 3'd2, MEMW = 3'd3,
                           REDIR = 3'd4, FLSH = 3'd5, HALT = 3'd6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        branch_req = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        load_use_hazard = 1'b0;
    logic        dm_busy = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;

    logic        pc_mux_sel;
    logic [15:0] jump_loc;
    logic        stall;
    logic        stall_pm;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        branch_ack;
    logic        stall_timeout;
    logic [2:0]  state_out;
    logic [15:0] stall_cycles;

    int    cyc = 0;
    int    n_checks = 0;
    int    n_pass = 0;
    int    tb_stall_cnt = 0;
    int    q_cyc[$];
    out_t  q_exp[$];
    string q_name[$];
    event  chk_ev;

    fetch_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .branch_req      (branch_req),
        .branch_target   (branch_target),
        .load_use_hazard (load_use_hazard),
        .dm_busy         (dm_busy),
        .halt_req        (halt_req),
        .resume          (resume),
        .pc_mux_sel      (pc_mux_sel),
        .jump_loc        (jump_loc),
        .stall           (stall),
        .stall_pm        (stall_pm),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .branch_ack      (branch_ack),
        .stall_timeout   (stall_timeout),
        .state_out       (state_out),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: compares every queued expectation that has come due.
    initial begin
        forever begin
            @(negedge clk or chk_ev);
            while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
                out_t  e;
                out_t  a;
                string nm;
                e  = q_exp.pop_front();
                nm = q_name.pop_front();
                void'(q_cyc.pop_front());
                a.st  = state_out;
                a.pcm = pc_mux_sel;
                a.jl  = jump_loc;
                a.stl = stall;
                a.spm = stall_pm;
                a.fif = flush_if_id;
                a.fid = flush_id_ex;
                a.ack = branch_ack;
                a.to  = stall_timeout;
                a.sc  = stall_cycles;
                n_checks++;
                if (a === e) begin
                    n_pass++;
                    $display("[%0t] %s ok st=%0d pcm=%0b jl=%h stall=%0b stall_pm=%0b fif=%0b fid=%0b ack=%0b to=%0b sc=%0d",
                             $time, nm, a.st, a.pcm, a.jl, a.stl, a.spm, a.fif, a.fid, a.ack, a.to, a.sc);
                end else begin
                    $display("FAIL %s: got st=%0d pcm=%0b jl=%h stall=%0b stall_pm=%0b fif=%0b fid=%0b ack=%0b to=%0b sc=%0d, want st=%0d pcm=%0b jl=%h stall=%0b stall_pm=%0b fif=%0b fid=%0b ack=%0b to=%0b sc=%0d",
                             nm, a.st, a.pcm, a.jl, a.stl, a.spm, a.fif, a.fid, a.ack, a.to, a.sc,
                             e.st, e.pcm, e.jl, e.stl, e.spm, e.fif, e.fid, e.ack, e.to, e.sc);
                end
            end
        end
    end

    task automatic push(input string nm, input int at, input logic [2:0] st,
                        input logic pcm, input logic [15:0] jl,
                        input logic stl, input logic spm, input logic fif,
                        input logic fid, input logic ack, input logic to);
        out_t e;
        if (stl) tb_stall_cnt++;
        e.st  = st;
        e.pcm = pcm;
        e.jl  = jl;
        e.stl = stl;
        e.spm = spm;
        e.fif = fif;
        e.fid = fid;
        e.ack = ack;
        e.to  = to;
`ifdef STALL_PERF_CNT_EN
        e.sc  = 16'(tb_stall_cnt);
`else
        e.sc  = 16'h0000;
`endif
        q_cyc.push_back(at);
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    // Expect these outputs after the next rising edge, then step past it.
    task automatic tick(input string nm, input logic [2:0] st,
                        input logic pcm, input logic [15:0] jl,
                        input logic stl, input logic spm, input logic fif,
                        input logic fid, input logic ack, input logic to);
        push(nm, cyc + 1, st, pcm, jl, stl, spm, fif, fid, ack, to);
        @(posedge clk);
        #1;
    endtask

    // Expect these outputs right now, with no clock edge in between.
    task automatic check_now(input string nm, input logic [2:0] st,
                             input logic pcm, input logic [15:0] jl,
                             input logic stl, input logic spm, input logic fif,
                             input logic fid, input logic ack, input logic to);
        push(nm, cyc, st, pcm, jl, stl, spm, fif, fid, ack, to);
        -> chk_ev;
        #1;
    endtask

    initial begin
        // ---------------- reset and boot ----------------
        #1 reset = 1'b0;
        @(negedge clk);
        #1;
        check_now("reset", BOOT, 1, 16'h0000, 0, 1, 0, 0, 0, 0);
        reset = 1'b1;
        tick("boot_edge1", BOOT, 1, 16'h0000, 0, 0, 0, 0, 0, 0);
        tick("boot_edge2", RUN,  0, 16'h0000, 0, 0, 0, 0, 0, 0);

        // ---------------- branch to 0x0008 ----------------
        branch_req = 1'b1; branch_target = 16'h0008;
        tick("br_redirect", REDIR, 1, 16'h0008, 0, 0, 1, 1, 1, 0);
        branch_req = 1'b0;
        tick("br_flush",    FLSH,  0, 16'h0008, 0, 0, 1, 0, 0, 0);
        tick("br_run",      RUN,   0, 16'h0008, 0, 0, 0, 0, 0, 0);

        // ---------------- single-cycle hazard ----------------
        load_use_hazard = 1'b1;
        tick("haz_stall", HAZ, 0, 16'h0008, 1, 1, 0, 1, 0, 0);
        load_use_hazard = 1'b0;
        tick("haz_run",   RUN, 0, 16'h0008, 0, 0, 0, 0, 0, 0);
        tick("haz_idle",  RUN, 0, 16'h0008, 0, 0, 0, 0, 0, 0);

        // ---------------- branch beats hazard ----------------
        load_use_hazard = 1'b1; branch_req = 1'b1; branch_target = 16'h1234;
        tick("hazbr_redirect", REDIR, 1, 16'h1234, 0, 0, 1, 1, 1, 0);
        load_use_hazard = 1'b0; branch_req = 1'b0;
        tick("hazbr_flush",    FLSH,  0, 16'h1234, 0, 0, 1, 0, 0, 0);
        tick("hazbr_run",      RUN,   0, 16'h1234, 0, 0, 0, 0, 0, 0);

        // ---------------- held hazard re-stalls from RUN ----------------
        load_use_hazard = 1'b1;
        tick("hazhold_stall1", HAZ, 0, 16'h1234, 1, 1, 0, 1, 0, 0);
        tick("hazhold_run",    RUN, 0, 16'h1234, 0, 0, 0, 0, 0, 0);
        tick("hazhold_stall2", HAZ, 0, 16'h1234, 1, 1, 0, 1, 0, 0);
        load_use_hazard = 1'b0;
        tick("hazhold_exit",   RUN, 0, 16'h1234, 0, 0, 0, 0, 0, 0);

        // ---------------- 20-cycle memory wait, timeout at 15 ----------------
        dm_busy = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick($sformatf("memwait_%0d", i), MEMW, 0, 16'h1234, 1, 1, 0, 0, 0, (i >= 15));
        end
        dm_busy = 1'b0;
        tick("memwait_exit", RUN, 0, 16'h1234, 0, 0, 0, 0, 0, 1);

        // ---------------- branch pending during memory wait ----------------
        dm_busy = 1'b1;
        tick("mwbr_wait1",    MEMW,  0, 16'h1234, 1, 1, 0, 0, 0, 1);
        branch_req = 1'b1; branch_target = 16'h00A0;
        tick("mwbr_wait2",    MEMW,  0, 16'h1234, 1, 1, 0, 0, 0, 1);
        dm_busy = 1'b0;
        tick("mwbr_run",      RUN,   0, 16'h1234, 0, 0, 0, 0, 0, 1);
        tick("mwbr_redirect", REDIR, 1, 16'h00A0, 0, 0, 1, 1, 1, 1);
        branch_req = 1'b0;
        tick("mwbr_flush",    FLSH,  0, 16'h00A0, 0, 0, 1, 0, 0, 1);
        tick("mwbr_done",     RUN,   0, 16'h00A0, 0, 0, 0, 0, 0, 1);

        // ---------------- halt with a branch pending ----------------
        halt_req = 1'b1; branch_req = 1'b1; branch_target = 16'h0055;
        tick("halt_enter",    HALT,  0, 16'h00A0, 1, 1, 0, 0, 0, 1);
        tick("halt_hold",     HALT,  0, 16'h00A0, 1, 1, 0, 0, 0, 1);
        halt_req = 1'b0; resume = 1'b1;
        tick("halt_resume",   RUN,   0, 16'h00A0, 0, 0, 0, 0, 0, 1);
        resume = 1'b0;
        tick("halt_redirect", REDIR, 1, 16'h0055, 0, 0, 1, 1, 1, 1);
        branch_req = 1'b0;
        tick("halt_flush",    FLSH,  0, 16'h0055, 0, 0, 1, 0, 0, 1);
        tick("halt_run",      RUN,   0, 16'h0055, 0, 0, 0, 0, 0, 1);

        // ---------------- resume while halt_req still high ----------------
        halt_req = 1'b1;
        tick("rehalt_enter",  HALT, 0, 16'h0055, 1, 1, 0, 0, 0, 1);
        resume = 1'b1;
        tick("rehalt_resume", RUN,  0, 16'h0055, 0, 0, 0, 0, 0, 1);
        resume = 1'b0;
        tick("rehalt_again",  HALT, 0, 16'h0055, 1, 1, 0, 0, 0, 1);
        halt_req = 1'b0; resume = 1'b1;
        tick("rehalt_exit",   RUN,  0, 16'h0055, 0, 0, 0, 0, 0, 1);
        resume = 1'b0;
        tick("rehalt_idle",   RUN,  0, 16'h0055, 0, 0, 0, 0, 0, 1);

        // ---------------- priority: halt > dm_busy, dm_busy > hazard -------
        halt_req = 1'b1; dm_busy = 1'b1;
        tick("prio_halt_mem", HALT, 0, 16'h0055, 1, 1, 0, 0, 0, 1);
        halt_req = 1'b0; dm_busy = 1'b0; resume = 1'b1;
        tick("prio_resume",   RUN,  0, 16'h0055, 0, 0, 0, 0, 0, 1);
        resume = 1'b0; dm_busy = 1'b1; load_use_hazard = 1'b1;
        tick("prio_mem_haz",  MEMW, 0, 16'h0055, 1, 1, 0, 0, 0, 1);
        dm_busy = 1'b0; load_use_hazard = 1'b0;
        tick("prio_run",      RUN,  0, 16'h0055, 0, 0, 0, 0, 0, 1);

        // ---------------- asynchronous reset during FLUSH ----------------
        branch_req = 1'b1; branch_target = 16'h0F0F;
        tick("ar_redirect", REDIR, 1, 16'h0F0F, 0, 0, 1, 1, 1, 1);
        branch_req = 1'b0;
        tick("ar_flush",    FLSH,  0, 16'h0F0F, 0, 0, 1, 0, 0, 1);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        tb_stall_cnt = 0;
        check_now("ar_async_reset", BOOT, 1, 16'h0000, 0, 1, 0, 0, 0, 0);
        reset = 1'b1;
        tick("ar_boot1", BOOT, 1, 16'h0000, 0, 0, 0, 0, 0, 0);
        tick("ar_boot2", RUN,  0, 16'h0000, 0, 0, 0, 0, 0, 0);
        tick("ar_idle",  RUN,  0, 16'h0000, 0, 0, 0, 0, 0, 0);

        // ---------------- drain the scoreboard ----------------
        repeat (2) @(negedge clk);
        #1;
        if (q_cyc.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q_cyc.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
